// File: rtl/note_dropper.sv
`default_nettype none
// ============================================================================
// Module   : note_dropper
// Purpose  : One falling note per instance: start delay, lane fall, and hit grading.
// Revision : 1.0
// ============================================================================
module note_dropper #(
    parameter logic [7:0] LANE_KEY    = 8'h07,
    parameter logic [7:0] START_KEY   = 8'h2C,
    parameter logic [7:0] RESTART_KEY = 8'h01,
    parameter logic [9:0] X_START     = 10'd160,
    parameter logic [9:0] Y_START     = 10'd100,
    parameter logic [9:0] Y_MAX       = 10'd400,
    parameter logic [9:0] ARROW_H     = 10'd40,
    parameter logic [9:0] HIT_LO      = 10'd340,
    parameter logic [9:0] PERF_LO     = 10'd360,
    parameter logic [9:0] PERF_HI     = 10'd380,
    parameter logic [9:0] SPEED       = 10'd1,
    parameter int         CNT_W       = 16,
    parameter int         START_DELAY = 2060
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [7:0] keycode_second,
    output logic [9:0] noteX,
    output logic [9:0] noteY,
    output logic       visible,
    output logic       hit,
    output logic       perfect,
    output logic       miss,
    output logic       score_pulse,
    output logic       done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_FALL = 3'd2;
    localparam logic [2:0] S_HIT  = 3'd3;
    localparam logic [2:0] S_MISS = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LAST = (START_DELAY == 0) ? '0 : CNT_W'(START_DELAY - 1);

    logic [2:0]       state_q, state_d;
    logic [9:0]       y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_down_q, prev_down_d;
    logic             visible_q, visible_d;
    logic             hit_q, hit_d;
    logic             perfect_q, perfect_d;
    logic             miss_q, miss_d;
    logic             score_pulse_q, score_pulse_d;
    logic             done_q, done_d;

    logic        lane_down;
    logic        press;
    logic        restart;
    logic [10:0] bottom;
    logic [10:0] y_plus;
    logic [10:0] y_plus_bottom;
    logic [9:0]  y_step;
    logic        in_perfect;

    assign lane_down   = (keycode == LANE_KEY) | (keycode_second == LANE_KEY);
    assign press       = lane_down & ~prev_down_q;
    assign restart     = (keycode == RESTART_KEY) | (keycode_second == RESTART_KEY);
    assign prev_down_d = lane_down;

    // 11-bit arithmetic so sprite bottom never wraps near the screen edge.
    assign bottom        = {1'b0, y_q} + {1'b0, ARROW_H};
    assign y_plus        = {1'b0, y_q} + {1'b0, SPEED};
    assign y_plus_bottom = y_plus + {1'b0, ARROW_H};
    assign y_step        = (y_plus_bottom > {1'b0, Y_MAX}) ? (Y_MAX - ARROW_H) : y_plus[9:0];
    assign in_perfect    = (bottom >= {1'b0, PERF_LO}) && (bottom < {1'b0, PERF_HI});

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            y_q           <= Y_START;
            cnt_q         <= '0;
            prev_down_q   <= 1'b0;
            visible_q     <= 1'b0;
            hit_q         <= 1'b0;
            perfect_q     <= 1'b0;
            miss_q        <= 1'b0;
            score_pulse_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            y_q           <= y_d;
            cnt_q         <= cnt_d;
            prev_down_q   <= prev_down_d;
            visible_q     <= visible_d;
            hit_q         <= hit_d;
            perfect_q     <= perfect_d;
            miss_q        <= miss_d;
            score_pulse_q <= score_pulse_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (keycode == START_KEY) begin
                    state_d = (START_DELAY == 0) ? S_FALL : S_WAIT;
                end
            end
            S_WAIT: begin
                if (restart) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FALL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FALL: begin
                // Miss check outranks a press so a late press on the line still misses.
                if (restart) begin
                    state_d = S_IDLE;
                end else if (bottom >= {1'b0, Y_MAX}) begin
                    state_d = S_MISS;
                end else if (press && (bottom >= {1'b0, HIT_LO})) begin
                    state_d = S_HIT;
                end else begin
                    y_d = y_step;
                end
            end
            S_HIT, S_MISS: begin
                if (restart) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE) begin
            y_d   = Y_START;
            cnt_d = '0;
        end
    end

    always_comb begin
        visible_d     = (state_d == S_WAIT) || (state_d == S_FALL);
        done_d        = (state_d == S_HIT) || (state_d == S_MISS);
        hit_d         = (state_d == S_HIT);
        miss_d        = (state_d == S_MISS);
        score_pulse_d = (state_q == S_FALL) && (state_d == S_HIT);
        perfect_d     = (state_d == S_HIT) && ((state_q == S_FALL) ? in_perfect : perfect_q);
    end

    assign noteX       = X_START;
    assign noteY       = y_q;
    assign visible     = visible_q;
    assign hit         = hit_q;
    assign perfect     = perfect_q;
    assign miss        = miss_q;
    assign score_pulse = score_pulse_q;
    assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_note_dropper.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_dropper
// Purpose  : Directed stimulus for note_dropper with a frame-arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_note_dropper;

    localparam int         D       = 5;
    localparam logic [7:0] K_LANE  = 8'h07;
    localparam logic [7:0] K_START = 8'h2C;
    localparam logic [7:0] K_RST   = 8'h01;
    localparam int         YS      = 100;
    localparam int         YMAX    = 400;
    localparam int         AH      = 40;
    localparam int         HLO     = 340;
    localparam int         PLO     = 360;
    localparam int         PHI     = 380;
    localparam int         SPD     = 1;

    logic       frame_clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] keycode = 8'h00;
    logic [7:0] keycode_second = 8'h00;
    logic [9:0] noteX, noteY;
    logic       visible, hit, perfect, miss, score_pulse, done;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    int pulse_total = 0;

    note_dropper #(.START_DELAY(D)) dut (
        .frame_clk      (frame_clk),
        .Reset          (Reset),
        .keycode        (keycode),
        .keycode_second (keycode_second),
        .noteX          (noteX),
        .noteY          (noteY),
        .visible        (visible),
        .hit            (hit),
        .perfect        (perfect),
        .miss           (miss),
        .score_pulse    (score_pulse),
        .done           (done)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: phase 0 idle, 1 running (m_t frames since start), 2 hit, 3 miss.
    int         m_phase = 0;
    int         m_t = 0;
    int         m_yfrz = YS;
    logic       m_prev = 1'b0;
    logic       m_perf = 1'b0;
    logic       m_pulse = 1'b0;

    function automatic int fall_y(input int t);
        int v;
        if (t <= D) return YS;
        v = YS + (t - D) * SPD;
        if (v > YMAX - AH) v = YMAX - AH;
        return v;
    endfunction

    function automatic int exp_y();
        if (m_phase == 0) return YS;
        if (m_phase == 1) return fall_y(m_t);
        return m_yfrz;
    endfunction

    always @(posedge frame_clk) begin : model
        logic lane, press, rk;
        int   yc, bot;
        lane  = (keycode == K_LANE) || (keycode_second == K_LANE);
        press = lane && !m_prev;
        rk    = (keycode == K_RST) || (keycode_second == K_RST);
        if (Reset) begin
            m_phase <= 0; m_t <= 0; m_prev <= 1'b0; m_perf <= 1'b0; m_pulse <= 1'b0;
        end else begin
            m_prev  <= lane;
            m_pulse <= 1'b0;
            if (m_phase == 0) begin
                if (keycode == K_START) begin m_phase <= 1; m_t <= 0; end
            end else if (rk) begin
                m_phase <= 0; m_perf <= 1'b0;
            end else if (m_phase == 1) begin
                if (m_t < D) begin
                    m_t <= m_t + 1;
                end else begin
                    yc  = fall_y(m_t);
                    bot = yc + AH;
                    if (bot >= YMAX) begin
                        m_phase <= 3; m_yfrz <= yc;
                    end else if (press && bot >= HLO) begin
                        m_phase <= 2; m_yfrz <= yc; m_pulse <= 1'b1;
                        m_perf  <= (bot >= PLO) && (bot < PHI);
                    end else begin
                        m_t <= m_t + 1;
                    end
                end
            end
        end
    end

    always @(negedge frame_clk) begin
        if (score_pulse === 1'b1) pulse_total++;
        if (chk_en) begin
            check("cyc_noteX",   noteX,       160);
            check("cyc_noteY",   noteY,       exp_y());
            check("cyc_visible", visible,     m_phase == 1);
            check("cyc_done",    done,        m_phase >= 2);
            check("cyc_hit",     hit,         m_phase == 2);
            check("cyc_miss",    miss,        m_phase == 3);
            check("cyc_perfect", perfect,     m_perf);
            check("cyc_pulse",   score_pulse, m_pulse);
        end
    end

    task automatic wait_frames(input int n);
        repeat (n) @(negedge frame_clk);
    endtask

    // Leaves the bench at the first WAIT frame (frame 1).
    task automatic start_note(input logic [7:0] k2);
        keycode = K_START; keycode_second = k2;
        wait_frames(1);
        keycode = 8'h00;
    endtask

    task automatic restart_note();
        keycode = K_RST; keycode_second = 8'h00;
        wait_frames(1);
        keycode = 8'h00;
        check("restart_y",   noteY,   100);
        check("restart_vis", visible, 0);
        check("restart_grd", {hit, perfect, miss, done}, 0);
    endtask

    // Frames after frame 1 until the note top reaches yv.
    function automatic int to_y(input int yv);
        return D + (yv - YS);
    endfunction

    int press_y  [5] = '{325, 305, 320, 340, 300};
    int press_pf [5] = '{1,   0,   1,   0,   0};

    initial begin
        wait_frames(3);
        Reset = 1'b0;
        chk_en = 1'b1;
        wait_frames(1);
        check("rst_noteX", noteX, 160);
        check("rst_noteY", noteY, 100);
        check("rst_flags", {visible, hit, perfect, miss, score_pulse, done}, 0);

        // Idle for 100 frames without the start key.
        wait_frames(100);
        check("idle_noteY", noteY, 100);
        check("idle_flags", {visible, hit, perfect, miss, score_pulse, done}, 0);

        // Delay count and unplayed miss.
        begin
            int p0;
            p0 = pulse_total;
            start_note(8'h00);
            check("dly_vis_f1", visible, 1);
            wait_frames(5);
            check("dly_y_f6", noteY, 100);
            wait_frames(1);
            check("dly_y_f7", noteY, 101);
            check("model_y_f7", exp_y(), 101);
            wait_frames(259);
            check("miss_y_last", noteY, 360);
            check("miss_pre", miss, 0);
            wait_frames(1);
            check("miss_flag", {miss, done, visible, hit}, 4'b1100);
            check("miss_y", noteY, 360);
            check("miss_no_pulse", pulse_total - p0, 0);
            restart_note();
        end

        // Graded presses: perfect/good and window boundaries.
        for (int i = 0; i < 5; i++) begin
            int p0;
            p0 = pulse_total;
            start_note(8'h00);
            wait_frames(to_y(press_y[i]));
            check("press_y", noteY, press_y[i]);
            keycode = K_LANE;
            wait_frames(1);
            keycode = 8'h00;
            check("press_hit",  {hit, done, visible, miss}, 4'b1100);
            check("press_perf", perfect, press_pf[i]);
            check("press_frz",  noteY, press_y[i]);
            wait_frames(2);
            check("press_hold", noteY, press_y[i]);
            check("press_pulse_cnt", pulse_total - p0, 1);
            restart_note();
        end
        check("model_perf_pin", m_perf, 0);

        // Held key on the second slot never scores.
        start_note(K_LANE);
        wait_frames(266);
        check("held_miss", {miss, hit}, 2'b10);
        check("held_y", noteY, 360);
        keycode_second = 8'h00;
        restart_note();

        // Early press ignored, later press hits; then Reset during HIT.
        start_note(8'h00);
        wait_frames(to_y(200));
        keycode = K_LANE;
        wait_frames(1);
        keycode = 8'h00;
        check("early_nohit", {hit, visible}, 2'b01);
        check("early_y", noteY, 201);
        wait_frames(109);
        check("late_y", noteY, 310);
        keycode = K_LANE;
        wait_frames(1);
        keycode = 8'h00;
        check("late_hit", {hit, perfect}, 2'b10);
        Reset = 1'b1;
        wait_frames(1);
        Reset = 1'b0;
        check("hitrst_y", noteY, 100);
        check("hitrst_flags", {visible, hit, perfect, miss, score_pulse, done}, 0);

        // Restart during FALL.
        start_note(8'h00);
        wait_frames(to_y(250));
        check("rfall_y", noteY, 250);
        restart_note();
        wait_frames(3);
        check("rfall_idle_y", noteY, 100);

        // Press below HIT_LO ignored; press on the miss line still misses.
        start_note(8'h00);
        wait_frames(to_y(299));
        keycode = K_LANE;
        wait_frames(1);
        keycode = 8'h00;
        check("lo_nohit", hit, 0);
        wait_frames(60);
        check("line_y", noteY, 360);
        keycode = K_LANE;
        wait_frames(1);
        keycode = 8'h00;
        check("line_miss", {miss, hit}, 2'b10);
        restart_note();

        wait_frames(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/note_dropper.md
# note_dropper

Parametrised single-lane falling-note engine for the rhythm game. It replaces the per-note hardwired dropper modules with one configurable block, instantiated once per note in the chart. Each instance does the following:

- waits a programmable number of frames after the start key;
- drops its note down a lane at a programmable speed;
- grades the player's key press as PERFECT, GOOD or MISS, using edge-detected keys and a programmable hit window.

Position, visibility and grade outputs feed the sprite renderer and the score accumulator.

## Interface
Parameters:
- LANE_KEY, 8'h07 — HID keycode that hits this note.
- START_KEY, 8'h2C — keycode that arms the block from IDLE.
- RESTART_KEY, 8'h01 — keycode that returns the block to IDLE from any state.
- X_START, 10'd160 — fixed lane X coordinate.
- Y_START, 10'd100 — initial note top Y.
- Y_MAX, 10'd400 — miss line; note bottom at or past it is a miss.
- ARROW_H, 10'd40 — sprite height; bottom = Y + ARROW_H.
- HIT_LO, 10'd340 — lowest bottom value that counts as a hit.
- PERF_LO, 10'd360 and PERF_HI, 10'd380 — PERFECT sub-window on bottom, half-open [PERF_LO, PERF_HI).
- SPEED, 10'd1 — pixels moved per frame.
- CNT_W, 16 — delay counter width.
- START_DELAY, 2060 — frames spent in WAIT; must be below 2^CNT_W.

Ports:
- frame_clk, in, 1 — frame clock (vsync rate).
- Reset, in, 1 — synchronous, active-high; clock frame_clk.
- keycode, in, 8 — first reported key.
- keycode_second, in, 8 — second reported key.
- noteX, out, 10 — always X_START.
- noteY, out, 10 — current note top Y.
- visible, out, 1 — renderer draws the note when high.
- hit, out, 1 — sticky; note was hit (GOOD or PERFECT).
- perfect, out, 1 — sticky; the hit landed in the PERFECT window.
- miss, out, 1 — sticky; note reached Y_MAX unhit.
- score_pulse, out, 1 — one-frame strobe on the frame the block enters HIT.
- done, out, 1 — high in HIT or MISS.

## Operation
- lane_down = (keycode==LANE_KEY) | (keycode_second==LANE_KEY).
- The prev_down register samples lane_down every frame in every state.
- press = lane_down & ~prev_down. A held key never scores.
- bottom = Y + ARROW_H, computed in 11 bits. All window compares use the 11-bit value, so there is no wrap.
- States: IDLE, WAIT, FALL, HIT, MISS.
- IDLE:
  - Y=Y_START, cnt=0, all grade outputs 0.
  - If keycode==START_KEY, next state is WAIT (or FALL directly if START_DELAY==0).
- WAIT:
  - If cnt==START_DELAY-1, next state is FALL; otherwise cnt++.
  - Y is held.
- FALL (evaluated with the current Y, priority order):
  1. bottom >= Y_MAX → MISS; set miss=1.
  2. Else press & bottom >= HIT_LO → HIT; set hit=1 and score_pulse=1. Set perfect=1 if PERF_LO <= bottom < PERF_HI.
  3. Else Y <= Y + SPEED. If Y+SPEED+ARROW_H exceeds Y_MAX, Y clamps to Y_MAX-ARROW_H.
- HIT and MISS:
  - Y and grades are held.
  - done=1, visible=0.
- RESTART_KEY in WAIT, FALL, HIT or MISS → IDLE next frame. This takes priority over every other transition and clears all grades.
- visible=1 only in WAIT and FALL.
- A press before HIT_LO is ignored and does not lock out a later press.

## Timing
- All state, Y, cnt, prev_down and outputs are registered on posedge frame_clk.
- Outputs are registered and reflect the state after the edge.
- Reset values:
  - state=IDLE, Y=Y_START, cnt=0, prev_down=0.
  - visible=hit=perfect=miss=score_pulse=done=0.
  - noteX=X_START.
- Reset mid-operation (any state) forces the reset values on the next edge.
- Start key seen at edge k → WAIT at k+1.
- FALL is entered at k+1+START_DELAY.
- First move is visible one frame after FALL is entered.
- With the defaults, bottom reaches HIT_LO after 200 moves and Y_MAX after 260 moves. The MISS decision is made on the next FALL frame.
- A press on the same frame that bottom >= Y_MAX scores MISS, not HIT.
- score_pulse is high for exactly one frame per HIT entry.

## Test plan
- Reset then idle: no start key for 100 frames → Y=100, visible=0, done=0, and all grades stay 0.
- Delay count: START_DELAY=5, start key at frame 0 → visible from frame 1, FALL at frame 6, Y=101 at frame 7.
- Miss: start with no presses (defaults) → Y stops at 360, then miss=1 and done=1 one frame later; hit=0 and score_pulse never asserted.
- Perfect vs good:
  - keycode=07 rising when Y=325 (bottom 365) → hit=1, perfect=1, score_pulse for 1 frame, Y frozen at 325.
  - Repeat with the press at Y=305 (bottom 345) → hit=1, perfect=0.
- Held and early key:
  - keycode_second=07 held from frame 0 through the whole window → no hit, miss at Y=360.
  - A press at Y=200 then release, then a press at Y=310 → hit=1.
- Restart and reset: RESTART_KEY during FALL at Y=250 → IDLE next frame, Y=100, grades 0. A Reset asserted during HIT → all outputs return to their reset values after one edge.
